// File: rtl/pearson8_rtl.sv
// pearson8_rtl: byte-serial 8-bit Pearson hash engine.
// Absorbs one character per enabled clock cycle into a registered 8-bit hash.
// Asserting init with enable restarts the hash from seed 0x00, which lets
// word delimiters begin a fresh token hash.
module pearson8_rtl (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       init,
    input  logic [7:0] char_in,
    output logic [7:0] hash_out
);

    // Permutation table T[x] = rotl3((167*x + 13) mod 256).
    // Every entry is an elaboration-time constant, so this is a pure ROM.
    logic [7:0] perm_rom_s [256];

    for (genvar gi = 0; gi < 256; gi++) begin : g_rom
        localparam logic [7:0] AFF = 8'((32'd167 * gi + 32'd13) % 32'd256);
        assign perm_rom_s[gi] = {AFF[4:0], AFF[7:5]};
    end

    logic [7:0] hash_q;
    logic [7:0] hash_d;
    logic [7:0] index_s;

    // Next-state: restart from seed 0 on init, else chain through the previous hash.
    always_comb begin
        hash_d  = hash_q;
        index_s = char_in;
        if (enable) begin
            if (init) begin
                index_s = char_in;
            end else begin
                index_s = hash_q ^ char_in;
            end
            hash_d = perm_rom_s[index_s];
        end else begin
            hash_d = hash_q;
        end
    end

    // Hash state register; reset clears it to seed 0x00 immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hash_q <= 8'h00;
        end else begin
            hash_q <= hash_d;
        end
    end

    assign hash_out = hash_q;

endmodule

// File: tb/tb_pearson8_rtl.sv
// Scoreboard bench for pearson8_rtl: the stimulus process pushes expected
// hash values into a queue, a monitor pops and compares after each edge.
module tb_pearson8_rtl;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       init;
    logic [7:0] char_in;
    logic [7:0] hash_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q [$];
    int         id_q  [$];
    logic [7:0] model_h = 8'h00;
    bit         seen [256];

    localparam int ID_RST    = 0;
    localparam int ID_TOKEN  = 1;
    localparam int ID_HOLD   = 2;
    localparam int ID_SEED   = 3;
    localparam int ID_TABLE  = 4;
    localparam int ID_RANDOM = 5;

    pearson8_rtl dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .init     (init),
        .char_in  (char_in),
        .hash_out (hash_out)
    );

    always #5 clock = ~clock;

    // Independent reference for the permutation table.
    function automatic logic [7:0] tref(input logic [7:0] x);
        logic [31:0] p;
        logic [7:0]  a;
        p = 32'd167 * {24'd0, x} + 32'd13;
        a = p[7:0];
        return {a[4:0], a[7:5]};
    endfunction

    function automatic string id_name(input int id);
        case (id)
            ID_RST:    return "reset_hold";
            ID_TOKEN:  return "token_stream";
            ID_HOLD:   return "enable_hold";
            ID_SEED:   return "seed_equiv";
            ID_TABLE:  return "table";
            ID_RANDOM: return "random";
            default:   return "unknown";
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: hash_out=%02h expected=%02h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus driven on the falling edge.
    // hand_ok selects a hand-computed expectation instead of the model value.
    task automatic step(input logic en, input logic ini, input logic [7:0] ch, input int id,
                        input bit hold_rst, input bit pulse_rst,
                        input bit hand_ok, input logic [7:0] hand);
        @(negedge clock);
        enable  = en;
        init    = ini;
        char_in = ch;
        if (hold_rst) begin
            reset   = 1'b0;
            model_h = 8'h00;
            #1;
            check("reset_low", hash_out, 8'h00);
        end else begin
            reset = 1'b1;
            if (pulse_rst) begin
                #2;
                reset = 1'b0;
                #1;
                check("async_reset", hash_out, 8'h00);
                model_h = 8'h00;
                #1;
                reset = 1'b1;
            end
            if (en) begin
                model_h = ini ? tref(ch) : tref(model_h ^ ch);
            end
        end
        exp_q.push_back(hand_ok ? hand : model_h);
        id_q.push_back(id);
    endtask

    // Monitor: after every rising edge, compare against the oldest expectation.
    initial begin
        logic [7:0] e;
        int         id;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                check(id_name(id), hash_out, e);
                if (id == ID_TABLE) seen[hash_out] = 1'b1;
            end
        end
    end

    initial begin
        logic [7:0] stream [5];
        logic [7:0] stream_exp [5];
        int distinct;
        int guard;

        reset   = 1'b0;
        enable  = 1'b0;
        init    = 1'b0;
        char_in = 8'h00;
        #1;
        check("reset_initial", hash_out, 8'h00);

        // Reset held with clock running and random inputs.
        for (int i = 0; i < 4; i++) begin
            step(1'($urandom), 1'($urandom), 8'($urandom), ID_RST, 1'b1, 1'b0, 1'b1, 8'h00);
        end

        // Token stream " test" twice.
        stream     = '{8'h20, 8'h74, 8'h65, 8'h73, 8'h74};
        stream_exp = '{8'h6F, 8'h55, 8'hEA, 8'hE6, 8'h5A};
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) begin
                step(1'b1, stream[i] == 8'h20, stream[i], ID_TOKEN, 1'b0, 1'b0, 1'b1, stream_exp[i]);
            end
        end

        // Hold with enable low while init/char_in toggle.
        step(1'b1, 1'b1, 8'h20, ID_HOLD, 1'b0, 1'b0, 1'b1, 8'h6F);
        step(1'b1, 1'b0, 8'h74, ID_HOLD, 1'b0, 1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b1, 8'hA5, ID_HOLD, 1'b0, 1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b0, 8'h3C, ID_HOLD, 1'b0, 1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b1, 8'hFF, ID_HOLD, 1'b0, 1'b0, 1'b1, 8'h55);
        step(1'b1, 1'b0, 8'h65, ID_HOLD, 1'b0, 1'b0, 1'b1, 8'hEA);

        // Seed equivalence after reset.
        step(1'b0, 1'b0, 8'h00, ID_RST,  1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'h00, ID_SEED, 1'b0, 1'b0, 1'b1, 8'h68);
        step(1'b1, 1'b1, 8'h00, ID_SEED, 1'b0, 1'b0, 1'b1, 8'h68);
        step(1'b1, 1'b1, 8'hFF, ID_SEED, 1'b0, 1'b0, 1'b1, 8'h33);

        // Mid-cycle asynchronous reset followed by a clean restart.
        step(1'b1, 1'b0, 8'h20, ID_SEED, 1'b0, 1'b1, 1'b1, 8'h6F);

        // Full table sweep.
        for (int x = 0; x < 256; x++) begin
            step(1'b1, 1'b1, 8'(x), ID_TABLE, 1'b0, 1'b0, 1'b0, 8'h00);
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), 8'($urandom),
                 ID_RANDOM, $urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
                 1'b0, 8'h00);
        end

        // Drain the scoreboard with a bounded wait.
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clock);
            guard++;
        end
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        distinct = 0;
        for (int x = 0; x < 256; x++) begin
            if (seen[x]) distinct++;
        end
        n_cmp++;
        if (distinct != 256) begin
            n_bad++;
            $display("FAIL table_distinct: distinct=%0d expected=256", distinct);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
